damage_scheduler: RTL and testbench
===================================

DAMAGE_SCHEDULER -- requirements
Module: damage_scheduler

Interface
REQ-001 Parameter NUM_UNITS, default 8: lanes per army; 2 <= NUM_UNITS <= 16.
REQ-002 Parameter AW, default 3: lane address width, equal to clog2(NUM_UNITS).
REQ-003 Parameter VW, default 8: width of the hp, atk and def fields.
REQ-004 clk  in  1  system clock; all state changes occur on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 damageSCEN  in  1  start request from the core FSM; sampled only in IDLE.
REQ-007 damageCalcACK  in  1  core acknowledge of a completed round.
REQ-008 damageCalcDone  out  1  round complete; held until acknowledged.
REQ-009 rd_en / rd_side / rd_addr  out  1/1/AW  unit RAM read strobe, army select (0 player, 1 enemy), lane.
REQ-010 rd_data  in  3*VW+1  {alive, hp, atk, def}, valid exactly 1 cycle after rd_en.
REQ-011 wr_en / wr_side / wr_addr  out  1/1/AW  unit RAM write strobe, army select, lane.
REQ-012 wr_hp / wr_alive  out  VW/1  new hp and new alive flag for the written unit.
REQ-013 kills_p / kills_e  out  AW+1/AW+1  enemy units killed by the player / player units killed by the enemy in the current round.

Function
REQ-014 States: IDLE, RD_P, RD_E, LATCH, CALC, WR_P, WR_E, ADV, DONE; encoding is one-hot.
REQ-015 IDLE: damageSCEN=1 -> RD_P, with lane=0 and kills_p=kills_e=0; otherwise remain in IDLE.
REQ-016 RD_P: rd_en=1, rd_side=0, rd_addr=lane; next state RD_E.
REQ-017 RD_E: capture the player record from rd_data; rd_en=1, rd_side=1, rd_addr=lane; next state LATCH.
REQ-018 LATCH: capture the enemy record; next state CALC.
REQ-019 CALC: compute both results from the pre-round captured values (simultaneous combat); next state WR_P.
REQ-020 dmg(a,d) = 0 if a=0; otherwise max(a-d,1), with a-d computed unsigned at VW+1 bits.
REQ-021 New hp = hp - dmg, saturating at 0; new alive = (new hp != 0).
REQ-022 A lane is active only when both units are alive; an inactive lane applies no damage.
REQ-023 WR_P: wr_en = lane active; wr_side=0; write the player's new hp and alive flag; next state WR_E.
REQ-024 WR_E: wr_en = lane active; wr_side=1; write the enemy's new hp and alive flag; next state ADV.
REQ-025 ADV: kills_p increments if the enemy transitioned alive->dead; kills_e increments if the player transitioned alive->dead; both may increment in the same cycle.
REQ-026 ADV: if lane = NUM_UNITS-1 -> DONE; otherwise lane+1 -> RD_P (no wrap past NUM_UNITS-1).
REQ-027 Latency: damageSCEN sampled at edge T -> damageCalcDone=1 from cycle T+7*NUM_UNITS+1.
REQ-028 DONE: damageCalcDone=1; damageCalcACK=1 -> IDLE. damageSCEN is ignored in DONE, including a same-cycle SCEN with ACK; SCEN must be re-asserted in IDLE.
REQ-029 damageSCEN is ignored in every state other than IDLE; damageCalcACK is ignored outside DONE.
REQ-030 rd_en and wr_en are never asserted together; at most one RAM strobe is active per cycle.
REQ-031 kills_p and kills_e are stable from ADV of the last lane until the next accepted start.
REQ-032 All outputs are registered; rd_*/wr_* hold 0 in any state that does not drive them.

Reset
REQ-033 reset=0 forces IDLE asynchronously and sets lane, captured records, kills_p, kills_e, damageCalcDone, rd_en, rd_side, rd_addr, wr_en, wr_side, wr_addr, wr_hp and wr_alive to 0.
REQ-034 Reset mid-round abandons the round with no further writes; lanes already written keep their new values.
REQ-035 Reset deassertion is synchronized so that the first state transition occurs no earlier than the second rising edge after deassertion.

Verification
REQ-036 Lane 0, player {1,10,5,2}, enemy {1,3,4,1} -> WR_P writes hp 8, alive 1; WR_E writes hp 0, alive 0; kills_p=1.
REQ-037 Player atk=3 vs enemy def=9 -> enemy loses exactly 1 hp; player atk=0 -> enemy loses 0 hp.
REQ-038 Both units at hp 1 with effective damage 1 -> both written dead; kills_p=1 and kills_e=1 in the same ADV.
REQ-039 Lane with enemy alive=0 -> wr_en stays 0 through WR_P/WR_E; NUM_UNITS=8 round gives Done at exactly T+57.
REQ-040 In DONE, ACK and SCEN both 1 -> IDLE with no restart; SCEN pulsed during RD_E -> ignored; reset asserted in WR_E -> no write, all outputs 0.

Source files
------------

// File: rtl/damage_scheduler_if.sv
// Unit-RAM and core-handshake bundle for the damage scheduler.
// The scheduler is the slave (it serves the core and drives the RAM port);
// the master side is the core FSM plus the unit RAM.
interface damage_scheduler_if #(
  parameter int AW = 3,
  parameter int VW = 8
);
  // Core handshake
  logic              damageSCEN;
  logic              damageCalcACK;
  logic              damageCalcDone;

  // Unit RAM read port; rd_data = {alive, hp, atk, def}
  logic              rd_en;
  logic              rd_side;
  logic [AW-1:0]     rd_addr;
  logic [3*VW:0]     rd_data;

  // Unit RAM write port (hp and alive only)
  logic              wr_en;
  logic              wr_side;
  logic [AW-1:0]     wr_addr;
  logic [VW-1:0]     wr_hp;
  logic              wr_alive;

  // Per-round kill counters
  logic [AW:0]       kills_p;
  logic [AW:0]       kills_e;

  modport slave (
    input  damageSCEN, damageCalcACK, rd_data,
    output damageCalcDone, rd_en, rd_side, rd_addr,
           wr_en, wr_side, wr_addr, wr_hp, wr_alive, kills_p, kills_e
  );

  modport master (
    output damageSCEN, damageCalcACK, rd_data,
    input  damageCalcDone, rd_en, rd_side, rd_addr,
           wr_en, wr_side, wr_addr, wr_hp, wr_alive, kills_p, kills_e
  );
endinterface

// File: rtl/damage_scheduler.sv
// Damage scheduler: walks every lane, reads the player and enemy unit
// records, resolves one simultaneous exchange of blows per lane, writes the
// new hp/alive values back and counts kills on each side.
module damage_scheduler #(
  parameter int NUM_UNITS = 8,
  parameter int AW        = 3,
  parameter int VW        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  damage_scheduler_if.slave     bus
);

  typedef enum logic [8:0] {
    IDLE  = 9'b0_0000_0001,
    RD_P  = 9'b0_0000_0010,
    RD_E  = 9'b0_0000_0100,
    LATCH = 9'b0_0000_1000,
    CALC  = 9'b0_0001_0000,
    WR_P  = 9'b0_0010_0000,
    WR_E  = 9'b0_0100_0000,
    ADV   = 9'b0_1000_0000,
    DONE  = 9'b1_0000_0000
  } state_t;

  localparam logic [AW-1:0] LAST_LANE = AW'(NUM_UNITS - 1);
  localparam logic [AW:0]   KILL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [VW-1:0] DMG_MIN   = {{(VW-1){1'b0}}, 1'b1};

  // Damage dealt by attack a against defence d: zero for a harmless
  // attacker, otherwise the difference with a floor of one point.
  function automatic logic [VW-1:0] dmg(input logic [VW-1:0] a,
                                        input logic [VW-1:0] d);
    logic [VW:0] diff;
    diff = {1'b0, a} - {1'b0, d};
    if (a == '0)
      dmg = '0;
    else if (diff[VW] || (diff[VW-1:0] == '0))
      dmg = DMG_MIN;
    else
      dmg = diff[VW-1:0];
  endfunction

  // hp minus damage, clamped at zero.
  function automatic logic [VW-1:0] sat_sub(input logic [VW-1:0] hp,
                                            input logic [VW-1:0] d);
    if (hp > d)
      sat_sub = hp - d;
    else
      sat_sub = '0;
  endfunction

  state_t          state_q;
  logic [1:0]      rst_sync_q;
  logic [AW-1:0]   lane_q;
  logic [3*VW:0]   p_rec_q;
  logic [3*VW:0]   e_rec_q;
  logic [AW:0]     kills_p_q;
  logic [AW:0]     kills_e_q;
  logic            done_q;
  logic            rd_en_q;
  logic            rd_side_q;
  logic [AW-1:0]   rd_addr_q;
  logic            wr_en_q;
  logic            wr_side_q;
  logic [AW-1:0]   wr_addr_q;
  logic [VW-1:0]   wr_hp_q;
  logic            wr_alive_q;

  // Field views of the captured records
  logic            p_alive, e_alive;
  logic [VW-1:0]   p_hp, p_atk, p_def;
  logic [VW-1:0]   e_hp, e_atk, e_def;
  logic            act;
  logic            run;
  logic [VW-1:0]   p_hp_d;
  logic [VW-1:0]   e_hp_d;

  assign p_alive = p_rec_q[3*VW];
  assign p_hp    = p_rec_q[3*VW-1:2*VW];
  assign p_atk   = p_rec_q[2*VW-1:VW];
  assign p_def   = p_rec_q[VW-1:0];
  assign e_alive = e_rec_q[3*VW];
  assign e_hp    = e_rec_q[3*VW-1:2*VW];
  assign e_atk   = e_rec_q[2*VW-1:VW];
  assign e_def   = e_rec_q[VW-1:0];

  // A lane fights only when both units are alive.
  assign act = p_alive & e_alive;

  // Starts are accepted only once the reset release has been synchronized.
  assign run = rst_sync_q[1];

  // Both results come from the pre-round records, so the exchange is
  // simultaneous; the records stay put until the next lane is read.
  always_comb begin
    p_hp_d = p_hp;
    e_hp_d = e_hp;
    if (act) begin
      p_hp_d = sat_sub(p_hp, dmg(e_atk, p_def));
      e_hp_d = sat_sub(e_hp, dmg(p_atk, e_def));
    end
  end

  // Reset release synchronizer: assertion is immediate, release takes two edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rst_sync_q <= 2'b00;
    else
      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // Round sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      p_rec_q    <= '0;
      e_rec_q    <= '0;
      kills_p_q  <= '0;
      kills_e_q  <= '0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_side_q  <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_side_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_hp_q    <= '0;
      wr_alive_q <= 1'b0;
    end else begin
      rd_en_q    <= 1'b0;
      rd_side_q  <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_side_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_hp_q    <= '0;
      wr_alive_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run && bus.damageSCEN) begin
            state_q   <= RD_P;
            lane_q    <= '0;
            kills_p_q <= '0;
            kills_e_q <= '0;
            rd_en_q   <= 1'b1;
            rd_side_q <= 1'b0;
            rd_addr_q <= '0;
          end
        end
        RD_P: begin
          state_q   <= RD_E;
          rd_en_q   <= 1'b1;
          rd_side_q <= 1'b1;
          rd_addr_q <= lane_q;
        end
        RD_E: begin
          p_rec_q <= bus.rd_data;
          state_q <= LATCH;
        end
        LATCH: begin
          e_rec_q <= bus.rd_data;
          state_q <= CALC;
        end
        CALC: begin
          state_q    <= WR_P;
          wr_en_q    <= act;
          wr_side_q  <= 1'b0;
          wr_addr_q  <= lane_q;
          wr_hp_q    <= p_hp_d;
          wr_alive_q <= (p_hp_d != '0);
        end
        WR_P: begin
          state_q    <= WR_E;
          wr_en_q    <= act;
          wr_side_q  <= 1'b1;
          wr_addr_q  <= lane_q;
          wr_hp_q    <= e_hp_d;
          wr_alive_q <= (e_hp_d != '0);
        end
        WR_E: begin
          // Kills become visible during ADV; an active lane means both
          // units entered the round alive, so a zero hp is a fresh kill.
          state_q <= ADV;
          if (act && (e_hp_d == '0))
            kills_p_q <= kills_p_q + KILL_ONE;
          if (act && (p_hp_d == '0))
            kills_e_q <= kills_e_q + KILL_ONE;
        end
        ADV: begin
          if (lane_q == LAST_LANE) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= RD_P;
            lane_q    <= lane_q + 1'b1;
            rd_en_q   <= 1'b1;
            rd_side_q <= 1'b0;
            rd_addr_q <= lane_q + 1'b1;
          end
        end
        DONE: begin
          // A start request arriving with the acknowledge is dropped.
          if (bus.damageCalcACK) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.damageCalcDone = done_q;
  assign bus.rd_en          = rd_en_q;
  assign bus.rd_side        = rd_side_q;
  assign bus.rd_addr        = rd_addr_q;
  assign bus.wr_en          = wr_en_q;
  assign bus.wr_side        = wr_side_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_hp          = wr_hp_q;
  assign bus.wr_alive       = wr_alive_q;
  assign bus.kills_p        = kills_p_q;
  assign bus.kills_e        = kills_e_q;

endmodule

// File: tb/tb_damage_scheduler.sv
// Directed bench for damage_scheduler with a behavioural unit RAM.
module tb_damage_scheduler;
  localparam int NU = 8;
  localparam int AW = 3;
  localparam int VW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  damage_scheduler_if #(.AW(AW), .VW(VW)) bus ();

  damage_scheduler #(.NUM_UNITS(NU), .AW(AW), .VW(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3*VW:0] pmem [NU];
  logic [3*VW:0] emem [NU];
  int n_vec = 0;
  int n_err = 0;

  // Unit RAM: one-cycle read latency, hp/alive write-back
  always @(posedge clk) begin
    if (bus.rd_en)
      bus.rd_data <= bus.rd_side ? emem[bus.rd_addr] : pmem[bus.rd_addr];
    if (bus.wr_en) begin
      if (bus.wr_side)
        emem[bus.wr_addr] <= {bus.wr_alive, bus.wr_hp, emem[bus.wr_addr][2*VW-1:0]};
      else
        pmem[bus.wr_addr] <= {bus.wr_alive, bus.wr_hp, pmem[bus.wr_addr][2*VW-1:0]};
    end
  end

  function automatic logic [3*VW:0] rec(input logic a, input logic [VW-1:0] hp,
                                        input logic [VW-1:0] atk, input logic [VW-1:0] def);
    rec = {a, hp, atk, def};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < NU; i++) begin
      pmem[i] <= rec(1'b0, 8'd0, 8'd0, 8'd0);
      emem[i] <= rec(1'b0, 8'd0, 8'd0, 8'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 of the round (lane 0 read of the player)
  task automatic start_round();
    bus.damageSCEN = 1'b1;
    step();
    bus.damageSCEN = 1'b0;
  endtask

  task automatic ack_round();
    bus.damageCalcACK = 1'b1;
    step();
    bus.damageCalcACK = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.damageSCEN = 1'b0;
    bus.damageCalcACK = 1'b0;
    repeat (2) step();
    n_vec++; if (bus.damageCalcDone !== 1'b0) begin n_err++; $display("FAIL rst_done got %0d want 0", bus.damageCalcDone); end
    n_vec++; if (bus.rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en got %0d want 0", bus.rd_en); end
    n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en got %0d want 0", bus.wr_en); end
    n_vec++; if (bus.kills_p !== 4'd0 || bus.kills_e !== 4'd0) begin n_err++; $display("FAIL rst_kills got %0d/%0d want 0/0", bus.kills_p, bus.kills_e); end
    // Start requested right across the release: the first edge must not start
    bus.damageSCEN = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    step();
    n_vec++; if (bus.rd_en !== 1'b0) begin n_err++; $display("FAIL rst_sync_first_edge rd_en got %0d want 0", bus.rd_en); end
    bus.damageSCEN = 1'b0;
    repeat (3) step();
    n_vec++; if (bus.rd_en !== 1'b0) begin n_err++; $display("FAIL rst_idle_after rd_en got %0d want 0", bus.rd_en); end
  endtask

  task automatic test_basic();
    int k;
    logic both;
    clear_mem();
    pmem[0] <= rec(1'b1, 8'd10, 8'd5, 8'd2);
    emem[0] <= rec(1'b1, 8'd3, 8'd4, 8'd1);
    pmem[1] <= rec(1'b1, 8'd50, 8'd1, 8'd1);
    emem[1] <= rec(1'b0, 8'd7, 8'd9, 8'd9);
    start_round();
    k = 1;
    both = 1'b0;
    while (bus.damageCalcDone !== 1'b1 && k < 200) begin
      if (bus.rd_en && bus.wr_en) both = 1'b1;
      if (k == 5) begin
        n_vec++; if ({bus.wr_en, bus.wr_side, bus.wr_hp, bus.wr_alive} !== {1'b1, 1'b0, 8'd8, 1'b1}) begin
          n_err++; $display("FAIL basic_wr_p en/side/hp/alive got %0d/%0d/%0d/%0d want 1/0/8/1", bus.wr_en, bus.wr_side, bus.wr_hp, bus.wr_alive); end
      end
      if (k == 6) begin
        n_vec++; if ({bus.wr_en, bus.wr_side, bus.wr_hp, bus.wr_alive} !== {1'b1, 1'b1, 8'd0, 1'b0}) begin
          n_err++; $display("FAIL basic_wr_e en/side/hp/alive got %0d/%0d/%0d/%0d want 1/1/0/0", bus.wr_en, bus.wr_side, bus.wr_hp, bus.wr_alive); end
      end
      if (k == 12 || k == 13) begin
        n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL inactive_lane_wr_en cycle %0d got %0d want 0", k, bus.wr_en); end
      end
      step();
      k++;
    end
    n_vec++; if (k !== 57) begin n_err++; $display("FAIL basic_latency got cycle %0d want 57", k); end
    n_vec++; if (both !== 1'b0) begin n_err++; $display("FAIL strobe_exclusive got %0d want 0", both); end
    n_vec++; if (bus.kills_p !== 4'd1 || bus.kills_e !== 4'd0) begin n_err++; $display("FAIL basic_kills got %0d/%0d want 1/0", bus.kills_p, bus.kills_e); end
    n_vec++; if (pmem[0][3*VW:2*VW] !== {1'b1, 8'd8}) begin n_err++; $display("FAIL basic_mem_p0 got %0h want 108", pmem[0][3*VW:2*VW]); end
    n_vec++; if (emem[0][3*VW:2*VW] !== {1'b0, 8'd0}) begin n_err++; $display("FAIL basic_mem_e0 got %0h want 0", emem[0][3*VW:2*VW]); end
    n_vec++; if (pmem[1][3*VW-1:2*VW] !== 8'd50 || emem[1][3*VW-1:2*VW] !== 8'd7) begin
      n_err++; $display("FAIL inactive_lane_mem got %0d/%0d want 50/7", pmem[1][3*VW-1:2*VW], emem[1][3*VW-1:2*VW]); end
    repeat (2) step();
    n_vec++; if (bus.damageCalcDone !== 1'b1) begin n_err++; $display("FAIL done_held got %0d want 1", bus.damageCalcDone); end
    ack_round();
    n_vec++; if (bus.damageCalcDone !== 1'b0) begin n_err++; $display("FAIL done_cleared got %0d want 0", bus.damageCalcDone); end
  endtask

  task automatic test_min_damage();
    int k;
    clear_mem();
    pmem[0] <= rec(1'b1, 8'd40, 8'd3, 8'd0);
    emem[0] <= rec(1'b1, 8'd20, 8'd0, 8'd9);
    pmem[1] <= rec(1'b1, 8'd30, 8'd0, 8'd4);
    emem[1] <= rec(1'b1, 8'd5, 8'd6, 8'd2);
    start_round();
    k = 1;
    while (bus.damageCalcDone !== 1'b1 && k < 200) begin step(); k++; end
    n_vec++; if (bus.damageCalcDone !== 1'b1) begin n_err++; $display("FAIL min_done_timeout got %0d want 1", bus.damageCalcDone); end
    n_vec++; if (emem[0][3*VW-1:2*VW] !== 8'd19) begin n_err++; $display("FAIL min_floor_one got %0d want 19", emem[0][3*VW-1:2*VW]); end
    n_vec++; if (pmem[0][3*VW-1:2*VW] !== 8'd40) begin n_err++; $display("FAIL min_zero_atk_p got %0d want 40", pmem[0][3*VW-1:2*VW]); end
    n_vec++; if (emem[1][3*VW-1:2*VW] !== 8'd5) begin n_err++; $display("FAIL min_zero_atk_e got %0d want 5", emem[1][3*VW-1:2*VW]); end
    n_vec++; if (pmem[1][3*VW-1:2*VW] !== 8'd28) begin n_err++; $display("FAIL min_normal_dmg got %0d want 28", pmem[1][3*VW-1:2*VW]); end
    n_vec++; if (bus.kills_p !== 4'd0 || bus.kills_e !== 4'd0) begin n_err++; $display("FAIL min_kills got %0d/%0d want 0/0", bus.kills_p, bus.kills_e); end
    ack_round();
  endtask

  task automatic test_mutual_kill_and_ack_scen();
    int k;
    clear_mem();
    pmem[2] <= rec(1'b1, 8'd1, 8'd1, 8'd5);
    emem[2] <= rec(1'b1, 8'd1, 8'd1, 8'd0);
    start_round();
    k = 1;
    while (bus.damageCalcDone !== 1'b1 && k < 200) begin
      if (k == 19) begin
        n_vec++; if ({bus.wr_en, bus.wr_hp, bus.wr_alive} !== {1'b1, 8'd0, 1'b0}) begin
          n_err++; $display("FAIL mutual_wr_p en/hp/alive got %0d/%0d/%0d want 1/0/0", bus.wr_en, bus.wr_hp, bus.wr_alive); end
      end
      if (k == 21) begin
        n_vec++; if (bus.kills_p !== 4'd1 || bus.kills_e !== 4'd1) begin
          n_err++; $display("FAIL mutual_kills_in_adv got %0d/%0d want 1/1", bus.kills_p, bus.kills_e); end
      end
      step();
      k++;
    end
    n_vec++; if (bus.kills_p !== 4'd1 || bus.kills_e !== 4'd1) begin n_err++; $display("FAIL mutual_kills_final got %0d/%0d want 1/1", bus.kills_p, bus.kills_e); end
    n_vec++; if (pmem[2][3*VW] !== 1'b0 || emem[2][3*VW] !== 1'b0) begin n_err++; $display("FAIL mutual_alive got %0d/%0d want 0/0", pmem[2][3*VW], emem[2][3*VW]); end
    // ACK together with SCEN: back to IDLE, no new round
    bus.damageCalcACK = 1'b1;
    bus.damageSCEN = 1'b1;
    step();
    bus.damageCalcACK = 1'b0;
    bus.damageSCEN = 1'b0;
    n_vec++; if (bus.damageCalcDone !== 1'b0 || bus.rd_en !== 1'b0) begin n_err++; $display("FAIL ack_scen done/rd_en got %0d/%0d want 0/0", bus.damageCalcDone, bus.rd_en); end
    step();
    n_vec++; if (bus.rd_en !== 1'b0) begin n_err++; $display("FAIL ack_scen_no_restart rd_en got %0d want 0", bus.rd_en); end
    n_vec++; if (bus.kills_p !== 4'd1) begin n_err++; $display("FAIL kills_stable_in_idle got %0d want 1", bus.kills_p); end
  endtask

  task automatic test_scen_ignored();
    int k;
    clear_mem();
    pmem[0] <= rec(1'b1, 8'd10, 8'd5, 8'd2);
    emem[0] <= rec(1'b1, 8'd3, 8'd4, 8'd1);
    start_round();
    k = 1;
    while (bus.damageCalcDone !== 1'b1 && k < 200) begin
      if (k == 2) bus.damageSCEN = 1'b1;
      if (k == 3) begin
        bus.damageSCEN = 1'b0;
        n_vec++; if (bus.rd_en !== 1'b0) begin n_err++; $display("FAIL scen_ignored_latch rd_en got %0d want 0", bus.rd_en); end
      end
      step();
      k++;
    end
    n_vec++; if (k !== 57) begin n_err++; $display("FAIL scen_ignored_latency got cycle %0d want 57", k); end
    n_vec++; if (bus.kills_p !== 4'd1) begin n_err++; $display("FAIL scen_ignored_kills got %0d want 1", bus.kills_p); end
    ack_round();
  endtask

  task automatic test_reset_mid_round();
    clear_mem();
    pmem[0] <= rec(1'b1, 8'd10, 8'd5, 8'd2);
    emem[0] <= rec(1'b1, 8'd9, 8'd4, 8'd1);
    start_round();
    repeat (5) step();
    n_vec++; if ({bus.wr_en, bus.wr_side, bus.wr_hp} !== {1'b1, 1'b1, 8'd5}) begin
      n_err++; $display("FAIL mid_pre_wr_e en/side/hp got %0d/%0d/%0d want 1/1/5", bus.wr_en, bus.wr_side, bus.wr_hp); end
    reset = 1'b0;
    #1;
    n_vec++; if ({bus.wr_en, bus.wr_side, bus.wr_hp, bus.wr_alive, bus.rd_en, bus.damageCalcDone} !== 13'd0) begin
      n_err++; $display("FAIL mid_reset_outputs wr_en/hp/rd_en/done got %0d/%0d/%0d/%0d want 0/0/0/0", bus.wr_en, bus.wr_hp, bus.rd_en, bus.damageCalcDone); end
    step();
    n_vec++; if (emem[0][3*VW:2*VW] !== {1'b1, 8'd9}) begin n_err++; $display("FAIL mid_reset_no_write got %0h want 109", emem[0][3*VW:2*VW]); end
    n_vec++; if (pmem[0][3*VW:2*VW] !== {1'b1, 8'd8}) begin n_err++; $display("FAIL mid_reset_kept_write got %0h want 108", pmem[0][3*VW:2*VW]); end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) step();
    n_vec++; if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin n_err++; $display("FAIL mid_reset_stays_idle got %0d/%0d want 0/0", bus.rd_en, bus.wr_en); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_damage();
    test_mutual_kill_and_ack_scen();
    test_scen_ignored();
    test_reset_mid_round();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
